// File: rtl/lsu_mem_stage_pkg.sv
// Shared types and decode helpers for the load/store memory stage.
package lsu_pkg;

  // FSM states of the memory stage
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WAIT  = 3'd2,
    MERGE = 3'd3,
    WR    = 3'd4,
    RESP  = 3'd5,
    ERR   = 3'd6
  } lsu_state_e;

  // RV32I funct3 size/sign encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Error causes reported on err_cause
  typedef enum logic [1:0] {
    CAUSE_LD_MISALIGN = 2'b00,
    CAUSE_ST_MISALIGN = 2'b01,
    CAUSE_TIMEOUT     = 2'b10,
    CAUSE_ILLEGAL     = 2'b11
  } err_cause_e;

  // Stores have no unsigned variants, so BU/HU are only legal on loads
  function automatic logic f3_valid(input logic [2:0] f3, input logic isStore);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~isStore;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always aligned
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Byte-lane logic: load extraction/extension and store read-modify-write merge.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_data,
  output logic [XLEN-1:0] st_word
);

  logic [7:0]  byteSel_s;
  logic [15:0] halfSel_s;

  // Pick the addressed byte/half and extend it to a full load result
  always_comb begin
    byteSel_s = 8'h00;
    halfSel_s = 16'h0000;
    ld_data   = word;
    case (offset)
      2'b00:   byteSel_s = word[7:0];
      2'b01:   byteSel_s = word[15:8];
      2'b10:   byteSel_s = word[23:16];
      default: byteSel_s = word[31:24];
    endcase
    if (offset[1]) begin
      halfSel_s = word[31:16];
    end else begin
      halfSel_s = word[15:0];
    end
    case (funct3)
      F3_B:    ld_data = {{24{byteSel_s[7]}}, byteSel_s};
      F3_BU:   ld_data = {24'h000000, byteSel_s};
      F3_H:    ld_data = {{16{halfSel_s[15]}}, halfSel_s};
      F3_HU:   ld_data = {16'h0000, halfSel_s};
      default: ld_data = word;
    endcase
  end

  // Overlay the store data onto the addressed lane of the word read back
  always_comb begin
    st_word = word;
    case (funct3)
      F3_B: begin
        case (offset)
          2'b00:   st_word = {word[31:8], wdata[7:0]};
          2'b01:   st_word = {word[31:16], wdata[7:0], word[7:0]};
          2'b10:   st_word = {word[31:24], wdata[7:0], word[15:0]};
          default: st_word = {wdata[7:0], word[23:0]};
        endcase
      end
      F3_H: begin
        if (offset[1]) begin
          st_word = {wdata[15:0], word[15:0]};
        end else begin
          st_word = {word[31:16], wdata[15:0]};
        end
      end
      F3_W:    st_word = wdata;
      default: st_word = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: drives a full-word RAM controller port, does
// sub-word loads by extraction and sub-word stores by read-modify-write.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15,
  localparam int ADDRWIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic                 ex_is_load,
  input  logic                 ex_is_store,
  input  logic [2:0]           ex_funct3,
  input  logic [XLEN-1:0]      ex_addr,
  input  logic [XLEN-1:0]      ex_wdata,
  input  logic [4:0]           ex_rd,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]      mem_wrData,
  output logic                 mem_wrEn,
  output logic                 mem_rdEn,
  output logic                 mem_byteEn,
  output logic                 mem_halfEn,
  output logic                 mem_wordEn,
  output logic                 mem_unsignedEn,
  input  logic [XLEN-1:0]      mem_dataOut,
  input  logic                 mem_outEn,
  output logic                 wb_valid,
  output logic [4:0]           wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic                 err_valid,
  output logic [1:0]           err_cause,
  output logic [XLEN-1:0]      err_addr
);

  localparam int CNTW = $clog2(TIMEOUT + 1);

  lsu_state_e            state_r, stateNext_s;
  logic                  accept_s;
  err_cause_e            errCause_s;
  logic [XLEN-1:0]       errAddr_s;

  logic                  reqIsLoad_r;
  logic [2:0]            reqFunct3_r;
  logic [XLEN-1:0]       reqAddr_r;
  logic [XLEN-1:0]       reqWdata_r;
  logic [4:0]            reqRd_r;
  logic [XLEN-1:0]       rdWord_r;
  logic [CNTW-1:0]       waitCnt_r;

  logic [XLEN-1:0]       alignWord_s;
  logic [XLEN-1:0]       ldData_s;
  logic [XLEN-1:0]       stWord_s;

  logic [ADDRWIDTH-1:0]  memAddr_r;
  logic [XLEN-1:0]       memWrData_r;
  logic                  memWrEn_r;
  logic                  memRdEn_r;
  logic                  wbValid_r;
  logic [4:0]            wbRd_r;
  logic [XLEN-1:0]       wbData_r;
  logic                  errValid_r;
  err_cause_e            errCause_r;
  logic [XLEN-1:0]       errAddr_r;

  // Loads extend straight from the RAM bus in WAIT; merges use the captured word
  assign alignWord_s = (state_r == WAIT) ? mem_dataOut : rdWord_r;

  lsu_align #(.XLEN(XLEN)) u_align (
    .word    (alignWord_s),
    .offset  (reqAddr_r[1:0]),
    .funct3  (reqFunct3_r),
    .wdata   (reqWdata_r),
    .ld_data (ldData_s),
    .st_word (stWord_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state decode, request acceptance and error classification
  always_comb begin
    stateNext_s = state_r;
    accept_s    = 1'b0;
    errCause_s  = CAUSE_ILLEGAL;
    errAddr_s   = reqAddr_r;
    case (state_r)
      IDLE: begin
        errAddr_s = ex_addr;
        if (ex_valid) begin
          accept_s = 1'b1;
          if (ex_is_load && ex_is_store) begin
            stateNext_s = ERR;
            errCause_s  = CAUSE_ILLEGAL;
          end else if (ex_is_load || ex_is_store) begin
            if (!f3_valid(ex_funct3, ex_is_store)) begin
              stateNext_s = ERR;
              errCause_s  = CAUSE_ILLEGAL;
            end else if (misaligned(ex_funct3, ex_addr[1:0])) begin
              stateNext_s = ERR;
              if (ex_is_store) begin
                errCause_s = CAUSE_ST_MISALIGN;
              end else begin
                errCause_s = CAUSE_LD_MISALIGN;
              end
            end else if (ex_is_store && (ex_funct3 == F3_W)) begin
              stateNext_s = WR;
            end else begin
              stateNext_s = RD;
            end
          end else begin
            // neither load nor store: swallowed without a response
            stateNext_s = IDLE;
          end
        end else begin
          stateNext_s = IDLE;
        end
      end
      RD:    stateNext_s = WAIT;
      WAIT: begin
        if (mem_outEn) begin
          if (reqIsLoad_r) begin
            stateNext_s = RESP;
          end else begin
            stateNext_s = MERGE;
          end
        end else if (waitCnt_r == CNTW'(TIMEOUT - 1)) begin
          stateNext_s = ERR;
          errCause_s  = CAUSE_TIMEOUT;
        end else begin
          stateNext_s = WAIT;
        end
      end
      MERGE: stateNext_s = WR;
      WR:    stateNext_s = IDLE;
      RESP:  stateNext_s = IDLE;
      ERR:   stateNext_s = IDLE;
      default: stateNext_s = IDLE;
    endcase
  end

  // Capture the accepted request and the word returned by the RAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reqIsLoad_r <= 1'b0;
      reqFunct3_r <= 3'b000;
      reqAddr_r   <= '0;
      reqWdata_r  <= '0;
      reqRd_r     <= 5'd0;
      rdWord_r    <= '0;
    end else begin
      if (accept_s) begin
        reqIsLoad_r <= ex_is_load;
        reqFunct3_r <= ex_funct3;
        reqAddr_r   <= ex_addr;
        reqWdata_r  <= ex_wdata;
        reqRd_r     <= ex_rd;
      end
      if ((state_r == WAIT) && mem_outEn) begin
        rdWord_r <= mem_dataOut;
      end
    end
  end

  // Count WAIT cycles since the read strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt_r <= '0;
    end else if (state_r == RD) begin
      waitCnt_r <= '0;
    end else if (state_r == WAIT) begin
      waitCnt_r <= waitCnt_r + CNTW'(1);
    end else begin
      waitCnt_r <= waitCnt_r;
    end
  end

  // Output registers, loaded from the state being entered so strobes align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memAddr_r   <= '0;
      memWrData_r <= '0;
      memWrEn_r   <= 1'b0;
      memRdEn_r   <= 1'b0;
      wbValid_r   <= 1'b0;
      wbRd_r      <= 5'd0;
      wbData_r    <= '0;
      errValid_r  <= 1'b0;
      errCause_r  <= CAUSE_LD_MISALIGN;
      errAddr_r   <= '0;
    end else begin
      memRdEn_r  <= (stateNext_s == RD);
      memWrEn_r  <= (stateNext_s == WR);
      wbValid_r  <= (stateNext_s == RESP);
      errValid_r <= (stateNext_s == ERR);
      if (accept_s) begin
        // upper address bits are dropped, so the RAM aliases
        memAddr_r <= ex_addr[ADDRWIDTH+1:2];
      end
      if (stateNext_s == WR) begin
        if (state_r == IDLE) begin
          memWrData_r <= ex_wdata;
        end else begin
          memWrData_r <= stWord_s;
        end
      end
      if (stateNext_s == RESP) begin
        wbRd_r   <= reqRd_r;
        wbData_r <= ldData_s;
      end
      if (stateNext_s == ERR) begin
        errCause_r <= errCause_s;
        errAddr_r  <= errAddr_s;
      end
    end
  end

  assign ex_ready       = (state_r == IDLE);
  assign mem_addr       = memAddr_r;
  assign mem_wrData     = memWrData_r;
  assign mem_wrEn       = memWrEn_r;
  assign mem_rdEn       = memRdEn_r;
  assign mem_byteEn     = 1'b0;
  assign mem_halfEn     = 1'b0;
  assign mem_wordEn     = 1'b1;
  assign mem_unsignedEn = 1'b0;
  assign wb_valid       = wbValid_r;
  assign wb_rd          = wbRd_r;
  assign wb_data        = wbData_r;
  assign err_valid      = errValid_r;
  assign err_cause      = errCause_r;
  assign err_addr       = errAddr_r;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: expected RAM strobes, writebacks and
// errors are queued when a request is driven and matched as the DUT emits them.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_is_load = 1'b0;
  logic        ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic [31:0] ex_addr = 32'h0;
  logic [31:0] ex_wdata = 32'h0;
  logic [4:0]  ex_rd = 5'd0;
  logic [11:0] mem_addr;
  logic [31:0] mem_wrData;
  logic        mem_wrEn, mem_rdEn, mem_byteEn, mem_halfEn, mem_wordEn, mem_unsignedEn;
  logic [31:0] mem_dataOut = 32'h0;
  logic        mem_outEn = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_valid;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;

  lsu_mem_stage #(.DEPTH(4096), .XLEN(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_funct3(ex_funct3), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .mem_addr(mem_addr), .mem_wrData(mem_wrData), .mem_wrEn(mem_wrEn),
    .mem_rdEn(mem_rdEn), .mem_byteEn(mem_byteEn), .mem_halfEn(mem_halfEn),
    .mem_wordEn(mem_wordEn), .mem_unsignedEn(mem_unsignedEn),
    .mem_dataOut(mem_dataOut), .mem_outEn(mem_outEn),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_valid(err_valid), .err_cause(err_cause), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [11:0] addr; logic [31:0] data; int cyc; } mem_ev_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; int cyc; } wb_ev_t;
  typedef struct { logic [1:0] cause; logic [31:0] addr; int cyc; } err_ev_t;

  mem_ev_t rdQ[$];
  mem_ev_t wrQ[$];
  wb_ev_t  wbQ[$];
  err_ev_t errQ[$];
  mem_ev_t mExp;
  wb_ev_t  wExp;
  err_ev_t eExp;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram [0:4095];
  logic        respEnable = 1'b1;
  logic        rdSeen = 1'b0;
  logic [11:0] rdAddr = 12'h0;

  // RAM model (read data one cycle after rdEn) and scoreboard monitor
  always @(negedge clk) begin
    mem_outEn   = rdSeen;
    mem_dataOut = rdSeen ? ram[rdAddr] : 32'h0;
    rdSeen      = mem_rdEn && respEnable;
    rdAddr      = mem_addr;
    checks++;
    if (mem_rdEn && mem_wrEn) begin
      errors++;
      $display("FAIL rd_wr_exclusive: got rdEn=1 wrEn=1 at cyc %0d, required not both", cyc);
    end
    if (mem_rdEn) begin
      checks++;
      if (rdQ.size() == 0) begin
        errors++;
        $display("FAIL rd_event: got unexpected rdEn addr=%h at cyc %0d, required none", mem_addr, cyc);
      end else begin
        mExp = rdQ.pop_front();
        if ({mem_addr, cyc} !== {mExp.addr, mExp.cyc}) begin
          errors++;
          $display("FAIL rd_event: got addr=%h cyc=%0d, required addr=%h cyc=%0d", mem_addr, cyc, mExp.addr, mExp.cyc);
        end
      end
    end
    if (mem_wrEn) begin
      checks++;
      if (wrQ.size() == 0) begin
        errors++;
        $display("FAIL wr_event: got unexpected wrEn addr=%h data=%h at cyc %0d, required none", mem_addr, mem_wrData, cyc);
      end else begin
        mExp = wrQ.pop_front();
        if ({mem_addr, mem_wrData, cyc} !== {mExp.addr, mExp.data, mExp.cyc}) begin
          errors++;
          $display("FAIL wr_event: got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                   mem_addr, mem_wrData, cyc, mExp.addr, mExp.data, mExp.cyc);
        end
      end
      ram[mem_addr] = mem_wrData;
    end
    if (wb_valid) begin
      checks++;
      if (wbQ.size() == 0) begin
        errors++;
        $display("FAIL wb_event: got unexpected wb rd=%0d data=%h at cyc %0d, required none", wb_rd, wb_data, cyc);
      end else begin
        wExp = wbQ.pop_front();
        if ({wb_rd, wb_data, cyc} !== {wExp.rd, wExp.data, wExp.cyc}) begin
          errors++;
          $display("FAIL wb_event: got rd=%0d data=%h cyc=%0d, required rd=%0d data=%h cyc=%0d",
                   wb_rd, wb_data, cyc, wExp.rd, wExp.data, wExp.cyc);
        end
      end
    end
    if (err_valid) begin
      checks++;
      if (errQ.size() == 0) begin
        errors++;
        $display("FAIL err_event: got unexpected err cause=%b addr=%h at cyc %0d, required none", err_cause, err_addr, cyc);
      end else begin
        eExp = errQ.pop_front();
        if ({err_cause, err_addr, cyc} !== {eExp.cause, eExp.addr, eExp.cyc}) begin
          errors++;
          $display("FAIL err_event: got cause=%b addr=%h cyc=%0d, required cause=%b addr=%h cyc=%0d",
                   err_cause, err_addr, cyc, eExp.cause, eExp.addr, eExp.cyc);
        end
      end
    end
  end

  function automatic void push_rd(input logic [11:0] a, input int c);
    rdQ.push_back('{addr: a, data: 32'h0, cyc: c});
  endfunction
  function automatic void push_wr(input logic [11:0] a, input logic [31:0] d, input int c);
    wrQ.push_back('{addr: a, data: d, cyc: c});
  endfunction
  function automatic void push_wb(input logic [4:0] r, input logic [31:0] d, input int c);
    wbQ.push_back('{rd: r, data: d, cyc: c});
  endfunction
  function automatic void push_err(input logic [1:0] ca, input logic [31:0] a, input int c);
    errQ.push_back('{cause: ca, addr: a, cyc: c});
  endfunction

  // Present one request on the next falling edge; c is the accept cycle
  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, output int c);
    @(negedge clk);
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_issue: got ex_ready=%b at cyc %0d, required 1", ex_ready, cyc);
    end
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
    c = cyc;
  endtask

  task automatic release_req();
    @(negedge clk);
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((rdQ.size() + wrQ.size() + wbQ.size() + errQ.size()) != 0 && n < 80) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if ((rdQ.size() + wrQ.size() + wbQ.size() + errQ.size()) != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d rd %0d wr %0d wb %0d err events outstanding, required 0",
               name, rdQ.size(), wrQ.size(), wbQ.size(), errQ.size());
      rdQ.delete(); wrQ.delete(); wbQ.delete(); errQ.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ex_ready, mem_wordEn} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ones: got ex_ready=%b wordEn=%b, required 1 1", ex_ready, mem_wordEn);
    end
    checks++;
    if ({mem_addr, mem_wrData, mem_wrEn, mem_rdEn, mem_byteEn, mem_halfEn, mem_unsignedEn,
         wb_valid, wb_rd, wb_data, err_valid, err_cause, err_addr} !== '0) begin
      errors++;
      $display("FAIL reset_zeros: got addr=%h wrData=%h wrEn=%b rdEn=%b wb=%b/%h err=%b/%b/%h, required all 0",
               mem_addr, mem_wrData, mem_wrEn, mem_rdEn, wb_valid, wb_data, err_valid, err_cause, err_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load_byte();
    int c;
    ram[12'h040] = 32'h80FF1234;
    drive(1'b1, 1'b0, F3_B, 32'h103, 32'h0, 5'd7, c);
    push_rd(12'h040, c + 1); push_wb(5'd7, 32'hFFFFFF80, c + 3);
    release_req(); wait_done("lb");
    drive(1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 5'd9, c);
    push_rd(12'h040, c + 1); push_wb(5'd9, 32'h00000080, c + 3);
    release_req(); wait_done("lbu");
  endtask

  task automatic test_load_variants();
    logic [2:0]  f3s  [6] = '{F3_H, F3_HU, F3_W, F3_B, F3_B, F3_HU};
    logic [31:0] adrs [6] = '{32'h102, 32'h102, 32'h4100, 32'h100, 32'h101, 32'h100};
    logic [31:0] exps [6] = '{32'hFFFF80FF, 32'h000080FF, 32'h80FF1234, 32'h00000034, 32'h00000012, 32'h00001234};
    int c;
    ram[12'h040] = 32'h80FF1234;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, f3s[i], adrs[i], 32'h0, 5'(i + 10), c);
      push_rd(12'h040, c + 1); push_wb(5'(i + 10), exps[i], c + 3);
      release_req(); wait_done("load_variant");
    end
  endtask

  task automatic test_store_rmw();
    int c;
    ram[12'h040] = 32'h11223344;
    drive(1'b0, 1'b1, F3_B, 32'h101, 32'h000000AB, 5'd0, c);
    push_rd(12'h040, c + 1); push_wr(12'h040, 32'h1122AB44, c + 4);
    release_req(); wait_done("sb");
    drive(1'b0, 1'b1, F3_H, 32'h102, 32'h1234CAFE, 5'd0, c);
    push_rd(12'h040, c + 1); push_wr(12'h040, 32'hCAFEAB44, c + 4);
    release_req(); wait_done("sh");
    drive(1'b0, 1'b1, F3_B, 32'h103, 32'hFFFFFF5A, 5'd0, c);
    push_rd(12'h040, c + 1); push_wr(12'h040, 32'h5AFEAB44, c + 4);
    release_req(); wait_done("sb_lane3");
    drive(1'b1, 1'b0, F3_W, 32'h100, 32'h0, 5'd1, c);
    push_rd(12'h040, c + 1); push_wb(5'd1, 32'h5AFEAB44, c + 3);
    release_req(); wait_done("lw_after_rmw");
  endtask

  task automatic test_store_word();
    int c;
    drive(1'b0, 1'b1, F3_W, 32'h008, 32'hDEADBEEF, 5'd0, c);
    push_wr(12'h002, 32'hDEADBEEF, c + 1);
    release_req();
    @(negedge clk);
    checks++;
    if ({ex_ready, cyc} !== {1'b1, c + 2}) begin
      errors++;
      $display("FAIL sw_ready: got ex_ready=%b at cyc %0d, required 1 at cyc %0d", ex_ready, cyc, c + 2);
    end
    wait_done("sw");
  endtask

  task automatic test_errors();
    logic        lds  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        sts  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3s  [7] = '{F3_H, F3_W, F3_W, F3_H, F3_HU, 3'b011, F3_W};
    logic [31:0] adrs [7] = '{32'h101, 32'h002, 32'h102, 32'h203, 32'h105, 32'h000, 32'h000};
    logic [1:0]  cau  [7] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b11, 2'b11};
    int c;
    for (int i = 0; i < 7; i++) begin
      drive(lds[i], sts[i], f3s[i], adrs[i], 32'h0, 5'd3, c);
      push_err(cau[i], adrs[i], c + 1);
      release_req(); wait_done("err");
    end
    // neither load nor store: accepted, no response
    drive(1'b0, 1'b0, F3_W, 32'h040, 32'h0, 5'd3, c);
    release_req();
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL drop_ready: got ex_ready=%b, required 1", ex_ready);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int c;
    drive(1'b0, 1'b1, F3_W, 32'h010, 32'hA5A55A5A, 5'd0, c);
    push_wr(12'h004, 32'hA5A55A5A, c + 1);
    release_req();
    drive(1'b1, 1'b0, F3_HU, 32'h012, 32'h0, 5'd20, c);
    push_rd(12'h004, c + 1); push_wb(5'd20, 32'h0000A5A5, c + 3);
    release_req(); wait_done("b2b");
  endtask

  task automatic test_timeout();
    int c;
    respEnable = 1'b0;
    drive(1'b1, 1'b0, F3_W, 32'h010, 32'h0, 5'd2, c);
    push_rd(12'h004, c + 1); push_err(2'b10, 32'h010, c + 2 + TIMEOUT);
    release_req(); wait_done("timeout");
    @(negedge clk);
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ready: got ex_ready=%b, required 1", ex_ready);
    end
    respEnable = 1'b1;
  endtask

  task automatic test_reset_mid_op();
    int c;
    respEnable = 1'b0;
    drive(1'b0, 1'b1, F3_H, 32'h102, 32'h00007777, 5'd0, c);
    push_rd(12'h040, c + 1);
    release_req();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ex_ready, mem_wordEn, dut.state_r == IDLE} !== 3'b111) begin
      errors++;
      $display("FAIL midrst_state: got ex_ready=%b wordEn=%b state=%0d, required 1 1 IDLE",
               ex_ready, mem_wordEn, dut.state_r);
    end
    checks++;
    if ({mem_addr, mem_wrData, mem_wrEn, mem_rdEn, mem_byteEn, mem_halfEn, mem_unsignedEn,
         wb_valid, wb_rd, wb_data, err_valid, err_cause, err_addr} !== '0) begin
      errors++;
      $display("FAIL midrst_zeros: got addr=%h wrData=%h wrEn=%b rdEn=%b wb=%b err=%b, required all 0",
               mem_addr, mem_wrData, mem_wrEn, mem_rdEn, wb_valid, err_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    respEnable = 1'b1;
    repeat (TIMEOUT + 6) @(negedge clk);
    wait_done("midrst");
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    test_reset();
    test_load_byte();
    test_load_variants();
    test_store_rmw();
    test_store_word();
    test_errors();
    test_back_to_back();
    test_timeout();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at cyc %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
